// File: rtl/sram_burst_ctrl.sv
// Burst controller for a negedge-sampled single-port SRAM with a tri-state data bus.
// Read and write bursts of req_len+1 beats, one beat per cycle, with registered SRAM controls.
module sram_burst_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  sram_cs,
    output logic                  sram_oe,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [DATA_WIDTH-1:0] sram_data,
    output logic [1:0]            dbg_state
);

    // Handshakes: a transfer happens on a posedge where valid and ready are both 1;
    // ready never depends on valid, and valid must hold until the transfer occurs.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_nx;
    logic [LEN_WIDTH-1:0]  beats, beats_nx;
    logic                  cs_nx, oe_nx, we_nx;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic [DATA_WIDTH-1:0] data_q, data_nx;

    always_comb begin
        state_nx    = state;
        cur_addr_nx = cur_addr;
        beats_nx    = beats;
        cs_nx       = 1'b0;
        oe_nx       = 1'b0;
        we_nx       = 1'b0;
        addr_nx     = sram_addr;
        data_nx     = data_q;
        req_ready   = 1'b0;
        wr_ready    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cur_addr_nx = req_addr;
                    beats_nx    = req_len;
                    state_nx    = req_we ? WRITE : READ;
                end
            end
            WRITE: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    cs_nx       = 1'b1;
                    we_nx       = 1'b1;
                    addr_nx     = cur_addr;
                    data_nx     = wr_data;
                    cur_addr_nx = cur_addr + ADDR_ONE;
                    beats_nx    = beats - LEN_ONE;
                    if (beats == '0) state_nx = IDLE;
                end
            end
            READ: begin
                cs_nx       = 1'b1;
                oe_nx       = 1'b1;
                addr_nx     = cur_addr;
                cur_addr_nx = cur_addr + ADDR_ONE;
                beats_nx    = beats - LEN_ONE;
                if (beats == '0) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_addr  <= '0;
            beats     <= '0;
            sram_cs   <= 1'b0;
            sram_oe   <= 1'b0;
            sram_we   <= 1'b0;
            sram_addr <= '0;
            data_q    <= '0;
        end else begin
            state     <= state_nx;
            cur_addr  <= cur_addr_nx;
            beats     <= beats_nx;
            sram_cs   <= cs_nx;
            sram_oe   <= oe_nx;
            sram_we   <= we_nx;
            sram_addr <= addr_nx;
            data_q    <= data_nx;
        end
    end

    // The SRAM presents read data from the negedge of the issue cycle; capture it one posedge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= sram_cs & sram_oe;
            if (sram_cs & sram_oe) rd_data <= sram_data;
        end
    end

    assign sram_data = (sram_cs & sram_we) ? data_q : 'z;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Bench for sram_burst_ctrl: a negedge-sampled SRAM model on the tri-state bus, directed
// and randomized bursts, and a scoreboard fed by a flat memory model.
module tb_sram_burst_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [3:0] req_len;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       busy;
    logic       sram_cs;
    logic       sram_oe;
    logic       sram_we;
    logic [7:0] sram_addr;
    wire  [7:0] sram_data;
    logic [1:0] dbg_state;

    sram_burst_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .LEN_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
        .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_data(sram_data), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- SRAM model ----------------
    logic [7:0] sram_mem [256];
    logic [7:0] sram_dout;
    logic       sram_drive;

    always @(negedge clk) begin
        if (sram_cs && sram_we) sram_mem[sram_addr] <= sram_data;
        if (sram_cs && sram_oe) sram_dout <= sram_mem[sram_addr];
    end
    assign sram_drive = sram_cs & sram_oe & ~sram_we;
    assign sram_data  = sram_drive ? sram_dout : 'z;

    // ---------------- reference model / scoreboard ----------------
    logic [7:0]  mdl_mem [256];
    logic [7:0]  exp_q[$];
    logic [15:0] exp_wr_q[$];
    int          iss_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sram_cs && sram_oe) begin
            check("no_contention", 32'(sram_we), 32'(0));
            iss_q.push_back(cyc);
        end
        if (sram_cs && sram_we) begin
            if (exp_wr_q.size() == 0) check("wr_extra", 32'(1), 32'(0));
            else begin
                logic [15:0] e;
                e = exp_wr_q.pop_front();
                check("wr_addr", 32'(sram_addr), 32'(e[15:8]));
                check("wr_data", 32'(sram_data), 32'(e[7:0]));
            end
        end
        if (rd_valid) begin
            if (exp_q.size() == 0 || iss_q.size() == 0) check("rd_extra", 32'(1), 32'(0));
            else begin
                int issued;
                issued = iss_q.pop_front();
                check("rd_latency", 32'(cyc), 32'(issued + 1));
                check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    logic [7:0]  wbuf [16];
    logic [31:0] stall_mask;
    int          last_cycles;

    task automatic wait_accept();
        int t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("req_ready", 32'(req_ready), 32'(1));
    endtask

    task automatic write_burst(input logic [7:0] addr, input logic [3:0] len);
        int n = int'(len) + 1;
        int i = 0;
        int k = 0;
        logic stall;
        req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_len = len;
        wait_accept();
        for (int b = 0; b < n; b++) begin
            logic [7:0] a;
            a = addr + 8'(b);
            mdl_mem[a] = wbuf[b];
            exp_wr_q.push_back({a, wbuf[b]});
        end
        @(negedge clk);
        req_valid = 1'b0;
        check("wr_busy", 32'(busy), 32'(1));
        while (i < n && k < 100) begin
            stall = (k < 32) && stall_mask[k];
            wr_valid = !stall;
            wr_data = stall ? 8'($urandom) : wbuf[i];
            check("wr_ready", 32'(wr_ready), 32'(1));
            @(negedge clk);
            if (stall) check("stall_cs", 32'(sram_cs), 32'(0));
            else begin
                check("beat_ctl", 32'({sram_cs, sram_oe, sram_we}), 32'(3'b101));
                i++;
            end
            k++;
        end
        wr_valid = 1'b0;
        last_cycles = k;
        check("wr_end_idle", 32'(req_ready), 32'(1));
    endtask

    task automatic read_burst(input logic [7:0] addr, input logic [3:0] len);
        int t = 0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_len = len;
        wait_accept();
        for (int b = 0; b <= int'(len); b++) exp_q.push_back(mdl_mem[addr + 8'(b)]);
        @(negedge clk);
        req_valid = 1'b0;
        while (exp_q.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("rd_done", 32'(exp_q.size()), 32'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int a = 0; a < 256; a++) begin
            sram_mem[a] = 8'h00;
            mdl_mem[a]  = 8'h00;
        end
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
        wr_valid = 1'b0; wr_data = '0; stall_mask = '0;
        repeat (2) @(negedge clk);
        check("rst_ctl", 32'({sram_cs, sram_oe, sram_we}), 32'(0));
        check("rst_addr", 32'(sram_addr), 32'(0));
        check("rst_rd", 32'({rd_valid, rd_data}), 32'(0));
        check("rst_hs", 32'({req_ready, wr_ready, busy}), 32'(3'b100));
        rst_n = 1'b1;
        @(negedge clk);

        // single write then read
        wbuf[0] = 8'hA5;
        write_burst(8'h10, 4'd0);
        read_burst(8'h10, 4'd0);

        // burst of 4, continuous
        wbuf[0] = 8'd1; wbuf[1] = 8'd2; wbuf[2] = 8'd3; wbuf[3] = 8'd4;
        write_burst(8'h20, 4'd3);
        check("b4_cycles", 32'(last_cycles), 32'(4));
        read_burst(8'h20, 4'd3);

        // two-cycle stall mid-burst
        for (int b = 0; b < 5; b++) wbuf[b] = 8'(8'h40 + b);
        stall_mask = 32'b1100;
        write_burst(8'h30, 4'd4);
        check("stall_cycles", 32'(last_cycles), 32'(7));
        stall_mask = '0;
        read_burst(8'h30, 4'd4);

        // address wrap
        wbuf[0] = 8'd7; wbuf[1] = 8'd8; wbuf[2] = 8'd9;
        write_burst(8'hFE, 4'd2);
        read_burst(8'hFE, 4'd2);
        read_burst(8'h00, 4'd0);

        // back-to-back write then read
        for (int b = 0; b < 6; b++) wbuf[b] = 8'($urandom);
        write_burst(8'h80, 4'd5);
        check("b2b_accept", 32'(req_ready), 32'(1));
        read_burst(8'h80, 4'd5);

        // randomized bursts
        for (int r = 0; r < 24; r++) begin
            logic [7:0] a;
            logic [3:0] l;
            a = 8'($urandom_range(0, 255));
            l = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b < 16; b++) wbuf[b] = 8'($urandom);
                stall_mask = $urandom() & $urandom();
                write_burst(a, l);
            end else begin
                read_burst(a, l);
            end
        end
        stall_mask = '0;

        // reset in the middle of a long read
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h20; req_len = 4'd15;
        wait_accept();
        for (int b = 0; b < 16; b++) exp_q.push_back(mdl_mem[8'h20 + 8'(b)]);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pre_oe", 32'(sram_oe), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ctl", 32'({sram_cs, sram_oe, sram_we}), 32'(0));
        check("rst_mid_rdv", 32'(rd_valid), 32'(0));
        check("rst_mid_busy", 32'(busy), 32'(0));
        exp_q.delete();
        iss_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rel_ready", 32'(req_ready), 32'(1));
        check("rst_rel_ctl", 32'({sram_cs, sram_oe, sram_we}), 32'(0));

        // bus still usable after reset
        wbuf[0] = 8'h3C; wbuf[1] = 8'hC3;
        write_burst(8'hFF, 4'd1);
        read_burst(8'hFF, 4'd1);

        repeat (3) @(negedge clk);
        check("wr_q_empty", 32'(exp_wr_q.size()), 32'(0));
        check("rd_q_empty", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
